// File: rtl/rv32i_types.sv
// Shared types for the cache/memory path: adaptor state encoding and
// line/beat widths.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } adaptor_state_t;

   localparam int S_LINE  = 256;
   localparam int S_BURST = 64;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one cache-line read/write from the cache into a fixed burst of
// memory beats, then pulses a single-cycle response back to the cache.
module cacheline_adaptor
   import rv32i_types::*;
#(
   parameter  int s_line  = S_LINE,
   parameter  int s_burst = S_BURST,
   localparam int s_beats = s_line / s_burst,
   localparam int beat_w  = $clog2(s_beats),
   localparam int ofs_w   = $clog2(s_line / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [s_line-1:0] line_i,
   output logic [s_line-1:0] line_o,
   input  logic [31:0]       address_i,
   input  logic              read_i,
   input  logic              write_i,
   output logic              resp_o,
   input  logic [s_burst-1:0] burst_i,
   output logic [s_burst-1:0] burst_o,
   output logic [31:0]       address_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
);

   localparam logic [beat_w-1:0] last_beat = beat_w'(s_beats - 1);

   adaptor_state_t    state_r;
   adaptor_state_t    state_next_s;
   logic [beat_w-1:0] beat_r;
   logic [beat_w-1:0] beat_next_s;
   logic [s_line-1:0] line_buf_r;

   // Next-state and beat-count logic.
   always_comb begin
      state_next_s = state_r;
      beat_next_s  = beat_r;
      case (state_r)
         IDLE: begin
            if (write_i) begin
               state_next_s = WRITE;
               beat_next_s  = '0;
            end else if (read_i) begin
               state_next_s = READ;
               beat_next_s  = '0;
            end else begin
               state_next_s = IDLE;
            end
         end
         READ, WRITE: begin
            if (resp_i) begin
               beat_next_s = beat_r + beat_w'(1);
               if (beat_r == last_beat) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = state_r;
               end
            end else begin
               beat_next_s = beat_r;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State and beat registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         beat_r  <= '0;
      end else begin
         state_r <= state_next_s;
         beat_r  <= beat_next_s;
      end
   end

   // Registered handshakes and datapath; strobes follow the next state so
   // they rise one cycle after acceptance and drop on the last ack edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_o     <= 1'b0;
         write_o    <= 1'b0;
         resp_o     <= 1'b0;
         address_o  <= 32'd0;
         burst_o    <= '0;
         line_o     <= '0;
         line_buf_r <= '0;
      end else begin
         read_o  <= (state_next_s == READ);
         write_o <= (state_next_s == WRITE);
         resp_o  <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (write_i) begin
                  line_buf_r <= line_i;
                  address_o  <= {address_i[31:ofs_w], {ofs_w{1'b0}}};
                  burst_o    <= line_i[s_burst-1:0];
               end else if (read_i) begin
                  address_o  <= {address_i[31:ofs_w], {ofs_w{1'b0}}};
               end
            end
            READ: begin
               if (resp_i) begin
                  line_o[s_burst*int'(beat_r) +: s_burst] <= burst_i;
               end
            end
            WRITE: begin
               // Present the following beat as soon as the current one is acked.
               if (resp_i) begin
                  burst_o <= line_buf_r[s_burst*int'(beat_next_s) +: s_burst];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
